// File: rtl/sound_mixer.sv
// Stereo mixer: snapshots four channel samples on a frame strobe, routes them per NR51,
// scales by NR50 and emits one stereo pair with a valid pulse. Option: SOUND_MIXER_OVERRUN_CNT_EN.
module sound_mixer #(
  parameter int SAMPLE_W  = 20,
  parameter int OUT_SHIFT = 5
) (
  input  logic                I_CLK,
  input  logic                I_RESET,
  input  logic                I_STROBE,
  input  logic [SAMPLE_W-1:0] I_CH1_WAVEFORM,
  input  logic [SAMPLE_W-1:0] I_CH2_WAVEFORM,
  input  logic [SAMPLE_W-1:0] I_CH3_WAVEFORM,
  input  logic [SAMPLE_W-1:0] I_CH4_WAVEFORM,
  input  logic [3:0]          I_CH_ON,
  input  logic [7:0]          I_NR50,
  input  logic [7:0]          I_NR51,
  input  logic                I_SOUND_EN,
  output logic [SAMPLE_W-1:0] O_LEFT,
  output logic [SAMPLE_W-1:0] O_RIGHT,
  output logic                O_VALID,
  output logic                O_BUSY,
`ifdef SOUND_MIXER_OVERRUN_CNT_EN
  output logic [7:0]          O_OVERRUN_CNT,
`endif
  output logic                O_OVERRUN
);

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_SCALE, S_OUT} state_t;

  state_t                     r_state, w_next;
  logic [1:0]                 r_idx;
  logic signed [SAMPLE_W-1:0] r_snap_ch [4];
  logic [3:0]                 r_snap_on;
  logic [7:0]                 r_nr51;
  logic [2:0]                 r_vol_l, r_vol_r;
  logic                       r_sound_en;
  logic signed [SAMPLE_W+1:0] r_acc_l, r_acc_r;
  logic [SAMPLE_W-1:0]        r_left, r_right;
  logic                       r_valid;

  logic signed [4:0]          w_gain_l, w_gain_r;
  logic signed [SAMPLE_W+5:0] w_prod_l, w_prod_r;
  logic                       w_unused_bits;
  logic                       w_accept;

  assign w_accept = (r_state == S_IDLE) && I_STROBE;

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge I_CLK) begin
    if (I_RESET) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // NOTE: w_next gets a default first so no path through the case can infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (I_STROBE) w_next = S_ACC;
      S_ACC:   if (r_idx == 2'd3) w_next = S_SCALE;
      S_SCALE: w_next = S_OUT;
      S_OUT:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // NOTE: snapshot registers carry no reset; they are always loaded before being read.
  always_ff @(posedge I_CLK) begin
    if (w_accept) begin
      r_snap_ch[0] <= I_CH1_WAVEFORM;
      r_snap_ch[1] <= I_CH2_WAVEFORM;
      r_snap_ch[2] <= I_CH3_WAVEFORM;
      r_snap_ch[3] <= I_CH4_WAVEFORM;
      r_snap_on    <= I_CH_ON;
      r_nr51       <= I_NR51;
      r_vol_l      <= I_NR50[6:4];
      r_vol_r      <= I_NR50[2:0];
      r_sound_en   <= I_SOUND_EN;
    end
  end

  assign w_gain_l = signed'({2'b00, r_vol_l}) + 5'sd1;
  assign w_gain_r = signed'({2'b00, r_vol_r}) + 5'sd1;
  assign w_prod_l = (SAMPLE_W+6)'(r_acc_l) * (SAMPLE_W+6)'(w_gain_l);
  assign w_prod_r = (SAMPLE_W+6)'(r_acc_r) * (SAMPLE_W+6)'(w_gain_r);
  assign w_unused_bits = ^{w_prod_l, w_prod_r, I_NR50[7], I_NR50[3]};

  // The scaled pair is registered on the SCALE->OUT edge so it is visible with O_VALID.
  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      r_idx   <= '0;
      r_acc_l <= '0;
      r_acc_r <= '0;
      r_left  <= '0;
      r_right <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: if (I_STROBE) begin
          r_idx   <= '0;
          r_acc_l <= '0;
          r_acc_r <= '0;
        end
        S_ACC: begin
          r_idx <= r_idx + 2'd1;
          if (r_snap_on[r_idx] && r_nr51[{1'b1, r_idx}])
            r_acc_l <= r_acc_l + (SAMPLE_W+2)'(r_snap_ch[r_idx]);
          if (r_snap_on[r_idx] && r_nr51[{1'b0, r_idx}])
            r_acc_r <= r_acc_r + (SAMPLE_W+2)'(r_snap_ch[r_idx]);
        end
        S_SCALE: begin
          r_left  <= r_sound_en ? w_prod_l[OUT_SHIFT +: SAMPLE_W] : '0;
          r_right <= r_sound_en ? w_prod_r[OUT_SHIFT +: SAMPLE_W] : '0;
          r_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef SOUND_MIXER_OVERRUN_CNT_EN
  logic [7:0] r_ovr_cnt;

  always_ff @(posedge I_CLK) begin
    if (I_RESET)
      r_ovr_cnt <= '0;
    else if (I_STROBE && (r_state != S_IDLE) && (r_ovr_cnt != 8'hFF))
      r_ovr_cnt <= r_ovr_cnt + 8'd1;
  end

  assign O_OVERRUN_CNT = r_ovr_cnt;
  assign O_OVERRUN     = |r_ovr_cnt;
`else
  logic r_overrun;

  always_ff @(posedge I_CLK) begin
    if (I_RESET)
      r_overrun <= 1'b0;
    else if (I_STROBE && (r_state != S_IDLE))
      r_overrun <= 1'b1;
  end

  assign O_OVERRUN = r_overrun;
`endif

  assign O_LEFT  = r_left;
  assign O_RIGHT = r_right;
  assign O_VALID = r_valid;
  assign O_BUSY  = (r_state != S_IDLE);

endmodule

// File: tb/tb_sound_mixer.sv
// Self-checking bench for sound_mixer: a frame-level reference model checked every cycle,
// plus directed frames with hand-computed results.
module tb_sound_mixer;
  localparam int SW = 20;

  logic                 I_CLK = 1'b0;
  logic                 I_RESET, I_STROBE, I_SOUND_EN;
  logic signed [SW-1:0] ch [4];
  logic [3:0]           I_CH_ON;
  logic [7:0]           I_NR50, I_NR51;
  logic [SW-1:0]        O_LEFT, O_RIGHT;
  logic                 O_VALID, O_BUSY, O_OVERRUN;
`ifdef SOUND_MIXER_OVERRUN_CNT_EN
  logic [7:0]           O_OVERRUN_CNT;
`endif

  sound_mixer #(.SAMPLE_W(SW), .OUT_SHIFT(5)) dut (
    .I_CLK(I_CLK), .I_RESET(I_RESET), .I_STROBE(I_STROBE),
    .I_CH1_WAVEFORM(ch[0]), .I_CH2_WAVEFORM(ch[1]),
    .I_CH3_WAVEFORM(ch[2]), .I_CH4_WAVEFORM(ch[3]),
    .I_CH_ON(I_CH_ON), .I_NR50(I_NR50), .I_NR51(I_NR51), .I_SOUND_EN(I_SOUND_EN),
    .O_LEFT(O_LEFT), .O_RIGHT(O_RIGHT), .O_VALID(O_VALID), .O_BUSY(O_BUSY),
`ifdef SOUND_MIXER_OVERRUN_CNT_EN
    .O_OVERRUN_CNT(O_OVERRUN_CNT),
`endif
    .O_OVERRUN(O_OVERRUN)
  );

  always #5 I_CLK = ~I_CLK;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: mix result from routing/volume rules, floor-divided by 32.
  function automatic longint mix_side(input bit left);
    longint acc = 0;
    longint p;
    int     gain;
    for (int k = 0; k < 4; k++)
      if (I_CH_ON[k] && (left ? I_NR51[4+k] : I_NR51[k])) acc += longint'(ch[k]);
    gain = left ? int'(I_NR50[6:4]) + 1 : int'(I_NR50[2:0]) + 1;
    p = acc * gain;
    if (!I_SOUND_EN) return 0;
    if (p >= 0) return p / 32;
    return -((-p + 31) / 32);
  endfunction

  bit     model_on = 0;
  int     cur      = 0;
  int     acc_cyc  = -100;
  int     val_cyc  = -100;
  int     free_at  = 0;
  int     ovr_cnt  = 0;
  longint pend_l = 0, pend_r = 0, held_l = 0, held_r = 0;

  always @(posedge I_CLK) begin
    if (I_RESET) begin
      model_on = 1;
      acc_cyc  = -100;
      val_cyc  = -100;
      free_at  = 0;
      ovr_cnt  = 0;
      held_l   = 0;
      held_r   = 0;
    end else begin
      if (I_STROBE) begin
        if (cur >= free_at) begin
          pend_l  = mix_side(1'b1);
          pend_r  = mix_side(1'b0);
          acc_cyc = cur;
          val_cyc = cur + 6;
          free_at = cur + 7;
        end else if (ovr_cnt < 255) begin
          ovr_cnt++;
        end
      end
      if (cur + 1 == val_cyc) begin
        held_l = pend_l;
        held_r = pend_r;
      end
    end
    cur++;
  end

  always @(negedge I_CLK) begin
    if (model_on) begin
      check("valid",   O_VALID,   (cur == val_cyc) ? 1 : 0);
      check("busy",    O_BUSY,    (cur > acc_cyc && cur <= val_cyc) ? 1 : 0);
      check("overrun", O_OVERRUN, (ovr_cnt != 0) ? 1 : 0);
      check("left",    $signed(O_LEFT),  held_l);
      check("right",   $signed(O_RIGHT), held_r);
`ifdef SOUND_MIXER_OVERRUN_CNT_EN
      check("overrun_cnt", O_OVERRUN_CNT, ovr_cnt);
`endif
    end
  end

  task automatic setup(input logic signed [SW-1:0] c0, c1, c2, c3, input logic [3:0] on,
                       input logic [7:0] nr50, nr51, input logic en);
    ch[0] = c0; ch[1] = c1; ch[2] = c2; ch[3] = c3;
    I_CH_ON = on; I_NR50 = nr50; I_NR51 = nr51; I_SOUND_EN = en;
  endtask

  task automatic pulse_strobe();
    I_STROBE = 1'b1;
    @(posedge I_CLK); #1;
    I_STROBE = 1'b0;
  endtask

  // Strobe, measure strobe-to-valid latency, then step to the first idle cycle.
  task automatic run_frame(input string name);
    int lat = -1;
    pulse_strobe();
    for (int i = 1; i <= 20; i++) begin
      if (O_VALID) begin
        lat = i;
        break;
      end
      @(posedge I_CLK); #1;
    end
    check({name, "_latency"}, lat, 6);
    @(posedge I_CLK); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int nv;
    I_RESET = 1'b1; I_STROBE = 1'b0;
    setup(0, 0, 0, 0, 4'h0, 8'h00, 8'h00, 1'b0);
    repeat (3) @(posedge I_CLK);
    #1 I_RESET = 1'b0;
    check("reset_left", $signed(O_LEFT), 0);
    check("reset_busy", O_BUSY, 0);

    setup(1000, 0, 0, 0, 4'b0001, 8'h77, 8'h11, 1'b1);
    run_frame("t1");
    check("t1_left",  $signed(O_LEFT),  250);
    check("t1_right", $signed(O_RIGHT), 250);

    setup(524287, 524287, 524287, 524287, 4'hF, 8'h70, 8'hF0, 1'b1);
    run_frame("t2");
    check("t2_left",  $signed(O_LEFT),  524287);
    check("t2_right", $signed(O_RIGHT), 0);

    setup(-524288, -524288, -524288, -524288, 4'hF, 8'h77, 8'hFF, 1'b1);
    run_frame("t3");
    check("t3_left",  $signed(O_LEFT),  -524288);
    check("t3_right", $signed(O_RIGHT), -524288);

    setup(0, 4096, 0, 0, 4'b0001, 8'h33, 8'h22, 1'b1);
    run_frame("t4a");
    check("t4a_left",  $signed(O_LEFT),  0);
    check("t4a_right", $signed(O_RIGHT), 0);

    setup(1000, 0, 0, 0, 4'b0001, 8'h77, 8'h11, 1'b0);
    run_frame("t4b");
    check("t4b_left",  $signed(O_LEFT),  0);
    check("t4b_right", $signed(O_RIGHT), 0);

    // Left = (-700-1)*3 = -2103 -> -66; right = (300+5)*6 = 1830 -> 57.
    setup(300, -700, 5, -1, 4'hF, 8'h25, 8'hA5, 1'b1);
    run_frame("mix");
    check("mix_left",  $signed(O_LEFT),  -66);
    check("mix_right", $signed(O_RIGHT), 57);

    // Second strobe three cycles into a frame.
    setup(1000, 0, 0, 0, 4'b0001, 8'h77, 8'h11, 1'b1);
    pulse_strobe();
    @(posedge I_CLK); #1;
    @(posedge I_CLK); #1;
    setup(-5000, 0, 0, 0, 4'b0001, 8'h77, 8'h11, 1'b1);
    pulse_strobe();
    nv = 0;
    for (int i = 0; i < 10 && !O_VALID; i++) begin
      @(posedge I_CLK); #1;
    end
    check("ovr_frame_valid", O_VALID, 1);
    check("ovr_frame_left",  $signed(O_LEFT), 250);
    repeat (12) begin
      @(posedge I_CLK); #1;
      nv += int'(O_VALID);
    end
    check("ovr_no_extra_valid", nv, 0);
    check("ovr_sticky", O_OVERRUN, 1);
`ifdef SOUND_MIXER_OVERRUN_CNT_EN
    check("ovr_cnt_one", O_OVERRUN_CNT, 1);
`endif

    // Strobe held high: back-to-back frames at the maximum rate, many ignored strobes.
    setup(300, -700, 5, -1, 4'hF, 8'h25, 8'hA5, 1'b1);
    I_STROBE = 1'b1;
    repeat (400) @(posedge I_CLK);
    #1 I_STROBE = 1'b0;
    repeat (8) @(posedge I_CLK);
    #1;
    check("stream_left", $signed(O_LEFT), -66);
`ifdef SOUND_MIXER_OVERRUN_CNT_EN
    check("ovr_cnt_sat", O_OVERRUN_CNT, 255);
`endif

    // Reset during accumulation of channel index 2.
    setup(1000, 0, 0, 0, 4'b0001, 8'h77, 8'h11, 1'b1);
    pulse_strobe();
    @(posedge I_CLK); #1;
    @(posedge I_CLK); #1;
    I_RESET = 1'b1;
    @(posedge I_CLK); #1;
    I_RESET = 1'b0;
    check("rst_left",    $signed(O_LEFT),  0);
    check("rst_right",   $signed(O_RIGHT), 0);
    check("rst_busy",    O_BUSY,    0);
    check("rst_valid",   O_VALID,   0);
    check("rst_overrun", O_OVERRUN, 0);
    run_frame("post_rst");
    check("post_rst_left",  $signed(O_LEFT),  250);
    check("post_rst_right", $signed(O_RIGHT), 250);

    repeat (3) @(posedge I_CLK);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
